// File: rtl/demux6b16_buf.sv
// ----------------------------------------------------------------------------
// demux6b16_buf
//
// Buffered 1-to-6 demultiplexer. This is the write side of the 6-input result
// mux. A producer offers one word plus a 3-bit destination under a
// valid/ready handshake. Each of the six destinations (A..F) owns a one-deep
// slot. A slot holds its word until that slot's consumer acknowledges it.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    word to route
//   in_sel     destination: 0..5 = A..F; 6 and 7 are illegal
//   in_valid   producer offers a word this cycle
//   in_ready   block will take the offered word this cycle (combinational)
//   out_A..F   slot contents (registered)
//   out_valid  bit i set = slot i holds an unconsumed word (bit0 = A)
//   out_ack    bit i set = consumer i takes slot i this cycle
//   clr_err    synchronous clear of sel_err and err_cnt
//   sel_err    sticky flag: an illegal select was accepted
//   err_cnt    saturating count of accepted illegal selects
// ----------------------------------------------------------------------------
module demux6b16_buf #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_VAL = 15,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [2:0]           in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out_A,
    output logic [WIDTH-1:0]     out_B,
    output logic [WIDTH-1:0]     out_C,
    output logic [WIDTH-1:0]     out_D,
    output logic [WIDTH-1:0]     out_E,
    output logic [WIDTH-1:0]     out_F,
    output logic [5:0]           out_valid,
    input  logic [5:0]           out_ack,
    input  logic                 clr_err,
    output logic                 sel_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic [WIDTH-1:0] slot_q [6];
    logic [5:0]       valid_q;
    logic [5:0]       slot_free;
    logic [7:0]       ready_by_sel;
    logic             legal_sel;
    logic             accept;

    // A slot can take a new word when it is empty, or when its current word
    // leaves in this same cycle. That second case gives full throughput.
    // Selects 6 and 7 are padded as always-ready so that illegal words are
    // drained and never stall the producer.
    assign slot_free    = ~valid_q | out_ack;
    assign ready_by_sel = {2'b11, slot_free};
    assign in_ready     = ready_by_sel[in_sel];
    assign legal_sel    = (in_sel < 3'd6);
    assign accept       = in_valid & in_ready;

    // Per-slot storage. A consume only clears the valid bit. The data stays
    // visible so downstream logic can keep reading the last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) begin
                slot_q[i] <= WIDTH'(DEFAULT_VAL);
            end
            valid_q <= '0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (accept && legal_sel && (in_sel == 3'(i))) begin
                    slot_q[i]  <= in_data;
                    valid_q[i] <= 1'b1;
                end else if (out_ack[i]) begin
                    valid_q[i] <= 1'b0;
                end
            end
        end
    end

    // Error bookkeeping. If a clear and an illegal accept arrive in the same
    // cycle, the clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err <= 1'b0;
            err_cnt <= '0;
        end else if (clr_err) begin
            sel_err <= 1'b0;
            err_cnt <= '0;
        end else if (accept && !legal_sel) begin
            sel_err <= 1'b1;
            if (err_cnt != '1) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

    assign out_A     = slot_q[0];
    assign out_B     = slot_q[1];
    assign out_C     = slot_q[2];
    assign out_D     = slot_q[3];
    assign out_E     = slot_q[4];
    assign out_F     = slot_q[5];
    assign out_valid = valid_q;

endmodule

// File: tb/tb_demux6b16_buf.sv
// ----------------------------------------------------------------------------
// tb_demux6b16_buf
//
// Testbench for demux6b16_buf. It combines three parts:
//   - a hand-derived vector table;
//   - a reference model of the slots and error counter;
//   - a per-slot scoreboard queue. A word is pushed when the producer's word
//     is accepted. It is popped and compared when the consumer acks it.
// ----------------------------------------------------------------------------
module tb_demux6b16_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_data;
    logic [2:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_A, out_B, out_C, out_D, out_E, out_F;
    logic [5:0]  out_valid;
    logic [5:0]  out_ack;
    logic        clr_err;
    logic        sel_err;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state and scoreboard.
    logic [15:0] m_data [6];
    logic [5:0]  m_valid;
    logic        m_err;
    logic [7:0]  m_cnt;
    logic [15:0] sbq [6][$];

    typedef struct {
        logic        v;
        logic [2:0]  sel;
        logic [15:0] data;
        logic [5:0]  ack;
        logic        clr;
        logic        exp_ready;
        logic [5:0]  exp_valid;
        logic        exp_err;
        logic [7:0]  exp_cnt;
        int          chk_slot;
        logic [15:0] exp_slot;
    } vec_t;

    vec_t vecs [10];

    demux6b16_buf #(.WIDTH(16), .DEFAULT_VAL(15), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
        .in_ready(in_ready),
        .out_A(out_A), .out_B(out_B), .out_C(out_C),
        .out_D(out_D), .out_E(out_E), .out_F(out_F),
        .out_valid(out_valid), .out_ack(out_ack),
        .clr_err(clr_err), .sel_err(sel_err), .err_cnt(err_cnt)
    );

    // 100 MHz free-running clock.
    always #5 clk = ~clk;

    function automatic logic [15:0] getOut(input int i);
        case (i)
            0:       return out_A;
            1:       return out_B;
            2:       return out_C;
            3:       return out_D;
            4:       return out_E;
            default: return out_F;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 6; i++) begin
            m_data[i] = 16'd15;
            sbq[i].delete();
        end
        m_valid = '0;
        m_err   = 1'b0;
        m_cnt   = '0;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'h0);
        checkOutput({tag, "_sel_err"},   32'(sel_err),   32'h0);
        checkOutput({tag, "_err_cnt"},   32'(err_cnt),   32'h0);
        for (int i = 0; i < 6; i++) begin
            checkOutput({tag, "_slot"}, 32'(getOut(i)), 32'd15);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_sel   = '0;
        in_data  = '0;
        out_ack  = '0;
        clr_err  = 1'b0;
    endtask

    // Drive one cycle of stimulus. Called shortly after a rising edge.
    // Checks in_ready against the model before the edge, and settles
    // scoreboard pops for acked slots. Returns just after the next edge,
    // having compared all registered outputs with the model.
    task automatic applyStimulus(input logic v, input logic [2:0] s, input logic [15:0] d,
                                 input logic [5:0] a, input logic c, output logic rdy);
        logic        exp_rdy;
        logic        acc;
        logic [5:0]  nv;
        logic [15:0] w;
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        out_ack  = a;
        clr_err  = c;
        #1;
        rdy     = in_ready;
        exp_rdy = (s >= 3'd6) ? 1'b1 : (!m_valid[s] || a[s]);
        checkOutput("in_ready", 32'(in_ready), 32'(exp_rdy));
        acc = v && exp_rdy;
        for (int i = 0; i < 6; i++) begin
            if (a[i] && m_valid[i]) begin
                if (sbq[i].size() == 0) begin
                    checkOutput("sb_queue_size", 32'(sbq[i].size()), 32'd1);
                end else begin
                    w = sbq[i].pop_front();
                    checkOutput("sb_word", 32'(getOut(i)), 32'(w));
                end
            end
        end
        nv = m_valid & ~a;
        if (acc && s < 3'd6) begin
            m_data[s] = d;
            nv[s]     = 1'b1;
            sbq[s].push_back(d);
        end
        m_valid = nv;
        if (c) begin
            m_err = 1'b0;
            m_cnt = '0;
        end else if (acc && s >= 3'd6) begin
            m_err = 1'b1;
            if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        end
        @(posedge clk);
        #1;
        checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
        checkOutput("sel_err",   32'(sel_err),   32'(m_err));
        checkOutput("err_cnt",   32'(err_cnt),   32'(m_cnt));
        for (int i = 0; i < 6; i++) begin
            checkOutput("slot_data", 32'(getOut(i)), 32'(m_data[i]));
        end
    endtask

    initial begin
        logic rdy;

        // Hand-derived vectors, applied in order straight after reset.
        vecs[0] = '{1'b1, 3'd3, 16'h1234, 6'b000000, 1'b0, 1'b1, 6'b001000, 1'b0, 8'd0, 3, 16'h1234};
        vecs[1] = '{1'b1, 3'd1, 16'hBBBB, 6'b000000, 1'b0, 1'b1, 6'b001010, 1'b0, 8'd0, 1, 16'hBBBB};
        vecs[2] = '{1'b1, 3'd1, 16'hCCCC, 6'b000000, 1'b0, 1'b0, 6'b001010, 1'b0, 8'd0, 1, 16'hBBBB};
        vecs[3] = '{1'b1, 3'd1, 16'hDDDD, 6'b000010, 1'b0, 1'b1, 6'b001010, 1'b0, 8'd0, 1, 16'hDDDD};
        vecs[4] = '{1'b0, 3'd7, 16'h0000, 6'b000000, 1'b0, 1'b1, 6'b001010, 1'b0, 8'd0, 3, 16'h1234};
        vecs[5] = '{1'b1, 3'd7, 16'hFFFF, 6'b000000, 1'b0, 1'b1, 6'b001010, 1'b1, 8'd1, 1, 16'hDDDD};
        vecs[6] = '{1'b1, 3'd6, 16'h5555, 6'b001000, 1'b0, 1'b1, 6'b000010, 1'b1, 8'd2, 3, 16'h1234};
        vecs[7] = '{1'b0, 3'd4, 16'h0000, 6'b010000, 1'b0, 1'b1, 6'b000010, 1'b1, 8'd2, 4, 16'h000F};
        vecs[8] = '{1'b0, 3'd0, 16'h0000, 6'b000010, 1'b1, 1'b1, 6'b000000, 1'b0, 8'd0, 1, 16'hDDDD};
        vecs[9] = '{1'b1, 3'd6, 16'h7777, 6'b000000, 1'b1, 1'b1, 6'b000000, 1'b0, 8'd0, 1, 16'hDDDD};

        // Power-on reset.
        idle();
        rst_n = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkResetState("por");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven vectors.
        for (int n = 0; n < 10; n++) begin
            applyStimulus(vecs[n].v, vecs[n].sel, vecs[n].data, vecs[n].ack, vecs[n].clr, rdy);
            checkOutput("tbl_ready", 32'(rdy),       32'(vecs[n].exp_ready));
            checkOutput("tbl_valid", 32'(out_valid), 32'(vecs[n].exp_valid));
            checkOutput("tbl_err",   32'(sel_err),   32'(vecs[n].exp_err));
            checkOutput("tbl_cnt",   32'(err_cnt),   32'(vecs[n].exp_cnt));
            checkOutput("tbl_slot",  32'(getOut(vecs[n].chk_slot)), 32'(vecs[n].exp_slot));
        end

        // 300 illegal words saturate the counter; then clear with a
        // same-cycle illegal accept.
        for (int n = 0; n < 300; n++) begin
            applyStimulus(1'b1, 3'd7, 16'(n), 6'b0, 1'b0, rdy);
        end
        checkOutput("sat_cnt", 32'(err_cnt), 32'hFF);
        checkOutput("sat_err", 32'(sel_err), 32'h1);
        applyStimulus(1'b1, 3'd6, 16'hABCD, 6'b0, 1'b1, rdy);
        checkOutput("clr_cnt", 32'(err_cnt), 32'h0);
        checkOutput("clr_err", 32'(sel_err), 32'h0);

        // Fan-out: fill A..F, then consume all six in one cycle.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 3'(i), 16'h000A + 16'(i), 6'b0, 1'b0, rdy);
        end
        checkOutput("fan_full", 32'(out_valid), 32'h3F);
        applyStimulus(1'b0, 3'd0, 16'h0, 6'h3F, 1'b0, rdy);
        checkOutput("fan_empty", 32'(out_valid), 32'h0);
        for (int i = 0; i < 6; i++) begin
            checkOutput("fan_keep", 32'(getOut(i)), 32'h000A + 32'(i));
        end

        // Random legal/illegal traffic with random acks.
        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 16'($urandom),
                          6'($urandom) & 6'($urandom), $urandom_range(0, 31) == 0, rdy);
        end
        applyStimulus(1'b0, 3'd0, 16'h0, 6'h3F, 1'b0, rdy);
        for (int i = 0; i < 6; i++) begin
            checkOutput("sb_drained", 32'(sbq[i].size()), 32'h0);
        end

        // Asynchronous reset mid-cycle, with words held.
        applyStimulus(1'b1, 3'd2, 16'h2222, 6'b0, 1'b0, rdy);
        applyStimulus(1'b1, 3'd7, 16'h9999, 6'b0, 1'b0, rdy);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkResetState("async");
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkResetState("post");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
